demux_4_buf: RTL

//   Registered 1-to-4 demultiplexer: steers one input word stream to one of four

---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_lane.sv | 45 ++++
 rtl/demux_4_buf.sv | 86 ++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared lane count, select width and lane index type for the 1-to-4 output demultiplexer.
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] lane_idx_t;

    function automatic logic [LANES-1:0] lane_onehot(input lane_idx_t idx);
        logic [LANES-1:0] hot;
        case (idx)
            2'd0:    hot = 4'b0001;
            2'd1:    hot = 4'b0010;
            2'd2:    hot = 4'b0100;
            2'd3:    hot = 4'b1000;
            default: hot = 4'b0000;
        endcase
        return hot;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry holding register for a single output lane with valid/ready drain.
module demux_lane #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [N-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [N-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;

    // A load on the same edge as a drain wins, so the lane stays full with the new word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Lane state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux_4_buf.sv
// Registered 1-to-4 demultiplexer with per-lane holding registers.
// Defining DEMUX4_RR_EN replaces in_sel with an internal round-robin lane pointer.
module demux_4_buf
    import demux_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data0,
    output logic [N-1:0] out_data1,
    output logic [N-1:0] out_data2,
    output logic [N-1:0] out_data3,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready
);

    lane_idx_t        tgt_s;
    logic             accept_s;
    logic [LANES-1:0] load_s;
    logic [N-1:0]     lane_data_s [LANES];

`ifdef DEMUX4_RR_EN
    lane_idx_t rr_q, rr_d;
    logic      unused_sel_s;

    assign unused_sel_s = ^in_sel;
    assign tgt_s        = rr_q;

    // Pointer moves only on an accepted word, so a stalled lane keeps it in place.
    always_comb begin
        rr_d = rr_q;
        if (accept_s) begin
            rr_d = rr_q + 2'd1;
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 2'd0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign tgt_s = lane_idx_t'(in_sel);
`endif

    // Accept when the target lane is empty or is being drained on this edge.
    always_comb begin
        in_ready = ~out_valid[tgt_s] | out_ready[tgt_s];
        accept_s = in_valid & in_ready;
        if (accept_s) begin
            load_s = lane_onehot(tgt_s);
        end else begin
            load_s = 4'b0000;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane #(
            .N (N)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load_s[k]),
            .data_i  (in_data),
            .ready_i (out_ready[k]),
            .valid_o (out_valid[k]),
            .data_o  (lane_data_s[k])
        );
    end

    assign out_data0 = lane_data_s[0];
    assign out_data1 = lane_data_s[1];
    assign out_data2 = lane_data_s[2];
    assign out_data3 = lane_data_s[3];

endmodule
